legv8_instr_encoder: RTL

Program-loader front end for the LEGv8 single-cycle core: accepts symbolic instructions (operation select, register numbers, immediate) over a valid/ready handshake. It encodes each one into a 32-bit R/D/CB/B-format word and writes it sequentially into instruction memory. It is the producer-side counterpart of the control-unit opcode decoder. The encodings it emits are exactly those the decoder recognises.

---
 rtl/legv8_isa_pkg.sv | 55 +++++
 rtl/legv8_instr_encoder_if.sv | 13 +
 rtl/legv8_instr_format.sv | 49 ++++
 rtl/legv8_instr_encoder.sv | 85 ++++++++
 4 files changed

// File: rtl/legv8_isa_pkg.sv
// LEGv8 ISA constants shared by the instruction encoder and the control-unit
// decoder: opcodes, the op_sel enumeration, field positions and immediate limits.
package legv8_isa_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_ORR  = 3'd3,
    OP_LDUR = 3'd4,
    OP_STUR = 3'd5,
    OP_CBZ  = 3'd6,
    OP_B    = 3'd7
  } opSel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FULL
  } encState_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam int OPC11_LSB  = 21;
  localparam int OPC8_LSB   = 24;
  localparam int OPC6_LSB   = 26;
  localparam int RM_LSB     = 16;
  localparam int DT_LSB     = 12;
  localparam int CB_IMM_LSB = 5;
  localparam int RN_LSB     = 5;
  localparam int RD_LSB     = 0;

  localparam logic signed [25:0] D_IMM_MIN  = -26'sd256;
  localparam logic signed [25:0] D_IMM_MAX  = 26'sd255;
  localparam logic signed [25:0] CB_IMM_MIN = -26'sd262144;
  localparam logic signed [25:0] CB_IMM_MAX = 26'sd262143;

  // R-format opcode for one of the four arithmetic/logic selections
  function automatic logic [10:0] rOpcode(opSel_e op);
    case (op)
      OP_SUB:  return OPC_SUB;
      OP_AND:  return OPC_AND;
      OP_ORR:  return OPC_ORR;
      default: return OPC_ADD;
    endcase
  endfunction

endpackage

// File: rtl/legv8_instr_encoder_if.sv
// Request channel carrying one symbolic instruction per valid/ready transfer.
interface legv8_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_sel;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [25:0] imm;

  modport master (output in_valid, op_sel, rd, rn, rm, imm, input in_ready);
  modport slave  (input in_valid, op_sel, rd, rn, rm, imm, output in_ready);
endinterface

// File: rtl/legv8_instr_format.sv
// Combinational encoder: symbolic instruction to 32-bit R/D/CB/B word plus an
// immediate range check. Fields a format does not use stay zero.
module legv8_instr_format
  import legv8_isa_pkg::*;
(
  input  logic [2:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  logic signed [25:0] immS;
  assign immS = $signed(imm);

  // Assemble the word for the selected format and judge the immediate
  always_comb begin
    word     = '0;
    range_ok = 1'b1;
    case (opSel_e'(op_sel))
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        word[OPC11_LSB +: 11] = rOpcode(opSel_e'(op_sel));
        word[RM_LSB +: 5]     = rm;
        word[RN_LSB +: 5]     = rn;
        word[RD_LSB +: 5]     = rd;
      end
      OP_LDUR, OP_STUR: begin
        word[OPC11_LSB +: 11] = (opSel_e'(op_sel) == OP_LDUR) ? OPC_LDUR : OPC_STUR;
        word[DT_LSB +: 9]     = imm[8:0];
        word[RN_LSB +: 5]     = rn;
        word[RD_LSB +: 5]     = rd;
        range_ok              = (immS >= D_IMM_MIN) && (immS <= D_IMM_MAX);
      end
      OP_CBZ: begin
        word[OPC8_LSB +: 8]    = OPC_CBZ;
        word[CB_IMM_LSB +: 19] = imm[18:0];
        word[RD_LSB +: 5]      = rd;
        range_ok               = (immS >= CB_IMM_MIN) && (immS <= CB_IMM_MAX);
      end
      default: begin
        word[OPC6_LSB +: 6] = OPC_B;
        word[25:0]          = imm;
      end
    endcase
  end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Program-loader front end: accepts symbolic instructions, encodes them and
// writes them one after another into instruction memory until it is full.
module legv8_instr_encoder
  import legv8_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  legv8_instr_encoder_if.slave  req,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  err
);

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'((1 << ADDR_W) - 1);

  encState_e   state;
  encState_e   nextState;
  logic [31:0] encWord;
  logic        rangeOk;
  logic        accept;

  legv8_instr_format formatter (
    .op_sel   (req.op_sel),
    .rd       (req.rd),
    .rn       (req.rn),
    .rm       (req.rm),
    .imm      (req.imm),
    .word     (encWord),
    .range_ok (rangeOk)
  );

  // restart wins over a simultaneous request, so ready drops while it is high
  assign req.in_ready = (state == ST_IDLE) && !rst && !restart;
  assign accept       = req.in_valid && req.in_ready;
  assign imem_we      = (state == ST_WRITE);
  assign full         = (state == ST_FULL);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  // Next state: accept into WRITE, then back to IDLE or into FULL on the last word
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  if (!restart && accept && rangeOk) nextState = ST_WRITE;
      ST_WRITE: begin
        if (restart)                  nextState = ST_IDLE;
        else if (count == LAST_COUNT) nextState = ST_FULL;
        else                          nextState = ST_IDLE;
      end
      ST_FULL:  if (restart) nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Write pointer, word count, latched encoding and the reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr  <= '0;
      count      <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      err <= accept && !rangeOk;
      if (accept && rangeOk) imem_wdata <= encWord;
      if (restart) begin
        imem_addr <= '0;
        count     <= '0;
      end else if (state == ST_WRITE) begin
        imem_addr <= imem_addr + ADDR_W'(1);
        count     <= count + (ADDR_W+1)'(1);
      end
    end
  end

endmodule
